// File: rtl/imem_fetch_arbiter.sv
//------------------------------------------------------------------------------
// Module   : imem_fetch_arbiter
// Purpose  : Shares the synchronous instruction ROM between CPU fetch and the
//            debug reader. Substitutes a NOP for bad fetches.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_fetch_arbiter #(
   parameter int          ADDR_W = 8,
   parameter int          DEPTH  = 32,
   parameter logic [31:0] NOP    = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_pc,
   output logic              if_ack,
   output logic [31:0]       if_inst,
   output logic              if_fault,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic [31:0]       dbg_data,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_inst,
   output logic              busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_CAP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic c_OWN_CPU = 1'b0;
   localparam logic c_OWN_DBG = 1'b1;

   localparam int              c_W1    = ADDR_W + 1;
   localparam logic [ADDR_W:0] c_DEPTH = c_W1'(DEPTH);

   logic [1:0]        r_state;
   logic              r_owner;
   logic              r_last_owner;
   logic              r_if_ack;
   logic [31:0]       r_if_inst;
   logic              r_if_fault;
   logic              r_dbg_ack;
   logic [31:0]       r_dbg_data;
   logic [ADDR_W-1:0] r_rom_addr;

   logic [ADDR_W-1:0] w_cpu_idx;
   logic              w_cpu_fault;
   logic              w_dbg_oor;
   logic              w_grant_cpu;
   logic              w_grant_dbg;

   assign w_cpu_idx   = if_pc[ADDR_W+1:2];
   assign w_cpu_fault = (if_pc[1:0] != 2'b00) || (|if_pc[31:ADDR_W+2]) ||
                        ({1'b0, w_cpu_idx} >= c_DEPTH);
   assign w_dbg_oor   = ({1'b0, dbg_addr} >= c_DEPTH);

   // On a tie the requester that was not granted last wins.
   assign w_grant_cpu = if_req && (!dbg_req || (r_last_owner == c_OWN_DBG));
   assign w_grant_dbg = dbg_req && !w_grant_cpu;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= c_OWN_CPU;
         r_last_owner <= c_OWN_DBG;
         r_if_ack     <= 1'b0;
         r_if_inst    <= NOP;
         r_if_fault   <= 1'b0;
         r_dbg_ack    <= 1'b0;
         r_dbg_data   <= 32'h0000_0000;
         r_rom_addr   <= '0;
      end else begin
         r_if_ack  <= 1'b0;
         r_dbg_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_cpu) begin
                  r_owner      <= c_OWN_CPU;
                  r_last_owner <= c_OWN_CPU;
                  if (w_cpu_fault) begin
                     r_if_inst  <= NOP;
                     r_if_fault <= 1'b1;
                     r_if_ack   <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_rom_addr <= w_cpu_idx;
                     r_state    <= S_READ;
                  end
               end else if (w_grant_dbg) begin
                  r_owner      <= c_OWN_DBG;
                  r_last_owner <= c_OWN_DBG;
                  if (w_dbg_oor) begin
                     r_dbg_data <= NOP;
                     r_dbg_ack  <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_rom_addr <= dbg_addr;
                     r_state    <= S_READ;
                  end
               end
            end
            S_READ: r_state <= S_CAP;
            S_CAP: begin
               // Acks are raised on entry so they coincide with DONE.
               if (r_owner == c_OWN_CPU) begin
                  r_if_inst  <= rom_inst;
                  r_if_fault <= 1'b0;
                  r_if_ack   <= 1'b1;
               end else begin
                  r_dbg_data <= rom_inst;
                  r_dbg_ack  <= 1'b1;
               end
               r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign if_ack   = r_if_ack;
   assign if_inst  = r_if_inst;
   assign if_fault = r_if_fault;
   assign dbg_ack  = r_dbg_ack;
   assign dbg_data = r_dbg_data;
   assign rom_addr = r_rom_addr;
   assign busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_imem_fetch_arbiter
// Purpose  : Scoreboarded randomized bench for imem_fetch_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_fetch_arbiter;

   localparam int          ADDR_W = 8;
   localparam int          DEPTH  = 32;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              if_req = 1'b0;
   logic [31:0]       if_pc = 32'h0;
   logic              if_ack;
   logic [31:0]       if_inst;
   logic              if_fault;
   logic              dbg_req = 1'b0;
   logic [ADDR_W-1:0] dbg_addr = '0;
   logic              dbg_ack;
   logic [31:0]       dbg_data;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_inst;
   logic              busy;

   imem_fetch_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_pc(if_pc), .if_ack(if_ack), .if_inst(if_inst), .if_fault(if_fault),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
      .rom_addr(rom_addr), .rom_inst(rom_inst), .busy(busy)
   );

   always #5 clk = ~clk;

   // ROM model: data for the sampled index one clock later.
   always @(posedge clk) rom_inst <= 32'hA500_0000 | {{(32-ADDR_W){1'b0}}, rom_addr};

   typedef struct packed {
      logic        src;   // 0 = CPU, 1 = debug
      logic [31:0] data;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference state derived from the arbitration and addressing rules.
   logic              m_last_dbg;
   logic [31:0]       m_if_inst;
   logic              m_fault;
   logic [31:0]       m_dbg;
   logic [ADDR_W-1:0] m_rom;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_last_dbg = 1'b1;
      m_if_inst  = NOP;
      m_fault    = 1'b0;
      m_dbg      = 32'h0;
      m_rom      = '0;
   endtask

   // Monitor: every ack consumes the oldest expected response.
   always @(negedge clk) begin
      if (if_ack || dbg_ack) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: if_ack=%0b dbg_ack=%0b, expected no ack", if_ack, dbg_ack);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ack_src", 32'(dbg_ack), 32'(e.src));
            if (e.src == 1'b0) begin
               check("if_inst", if_inst, e.data);
               check("if_fault", 32'(if_fault), 32'(e.fault));
            end else begin
               check("dbg_data", dbg_data, e.data);
            end
         end
      end
   end

   task automatic check_steady();
      check("steady_busy", 32'(busy), 32'h0);
      check("steady_if_inst", if_inst, m_if_inst);
      check("steady_if_fault", 32'(if_fault), 32'(m_fault));
      check("steady_dbg_data", dbg_data, m_dbg);
      check("steady_rom_addr", 32'(rom_addr), 32'(m_rom));
   endtask

   task automatic do_txn(input logic use_cpu, input logic use_dbg,
                         input logic [31:0] pc, input logic [ADDR_W-1:0] da);
      logic c_ok, d_ok, cpu_first;
      int   lat_c, lat_d, exp_c, exp_d, got_c, got_d;
      exp_t ec, ed;
      c_ok  = (pc[1:0] == 2'b00) && ((pc >> 2) < 32'(DEPTH));
      d_ok  = (32'(da) < 32'(DEPTH));
      lat_c = c_ok ? 3 : 1;
      lat_d = d_ok ? 3 : 1;
      ec    = '{1'b0, (c_ok ? (32'hA500_0000 | (pc >> 2)) : NOP), !c_ok};
      ed    = '{1'b1, (d_ok ? (32'hA500_0000 | 32'(da)) : NOP), 1'b0};
      cpu_first = use_cpu && (!use_dbg || m_last_dbg);
      if (use_cpu && use_dbg) begin
         exp_c = cpu_first ? lat_c : lat_d + 1 + lat_c;
         exp_d = cpu_first ? lat_c + 1 + lat_d : lat_d;
      end else begin
         exp_c = lat_c;
         exp_d = lat_d;
      end
      @(negedge clk);
      if (cpu_first) begin
         if (use_cpu) exp_q.push_back(ec);
         if (use_dbg) exp_q.push_back(ed);
      end else begin
         if (use_dbg) exp_q.push_back(ed);
         if (use_cpu) exp_q.push_back(ec);
      end
      if_req = use_cpu; if_pc = pc; dbg_req = use_dbg; dbg_addr = da;
      got_c = 0; got_d = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check("busy_c1", 32'(busy), 32'h1);
            if ((use_cpu != use_dbg) && (use_cpu ? c_ok : d_ok))
               check("rom_addr_c1", 32'(rom_addr), use_cpu ? (pc >> 2) : 32'(da));
         end
         if (if_ack)  begin got_c = c; if_req  = 1'b0; end
         if (dbg_ack) begin got_d = c; dbg_req = 1'b0; end
         if (!if_req && !dbg_req) break;
      end
      if_req = 1'b0; dbg_req = 1'b0;
      if (use_cpu) check("if_ack_cycle", got_c, exp_c);
      if (use_dbg) check("dbg_ack_cycle", got_d, exp_d);
      if (cpu_first) begin
         if (use_cpu && c_ok) m_rom = pc[ADDR_W+1:2];
         if (use_dbg && d_ok) m_rom = da;
      end else begin
         if (use_dbg && d_ok) m_rom = da;
         if (use_cpu && c_ok) m_rom = pc[ADDR_W+1:2];
      end
      if (use_cpu) begin m_if_inst = ec.data; m_fault = ec.fault; end
      if (use_dbg) m_dbg = ed.data;
      m_last_dbg = (use_cpu && use_dbg) ? cpu_first : use_dbg;
      @(negedge clk);
      check_steady();
   endtask

   task automatic held_test();
      int k;
      int got[3];
      k = 0;
      got = '{0, 0, 0};
      @(negedge clk);
      for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 32'hA500_0000 | 32'(i), 1'b0});
      if_req = 1'b1; if_pc = 32'h0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (if_ack) begin
            got[k] = c;
            k++;
            if_pc = if_pc + 32'd4;
            if (k == 3) break;
         end
      end
      if_req = 1'b0;
      for (int i = 0; i < 3; i++) check("held_ack_cycle", got[i], 3 + 4 * i);
      m_if_inst = 32'hA500_0002; m_fault = 1'b0; m_rom = 8'd2; m_last_dbg = 1'b0;
      @(negedge clk);
      check_steady();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; if_req = 1'b0; dbg_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pc;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_if_inst", if_inst, NOP);
      check("rst_dbg_data", dbg_data, 32'h0);
      check("rst_if_fault", 32'(if_fault), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_rom_addr", 32'(rom_addr), 32'h0);
      check("rst_acks", {30'h0, if_ack, dbg_ack}, 32'h0);
      rst = 1'b0;

      do_txn(1'b1, 1'b0, 32'h0000_000C, '0);
      do_txn(1'b1, 1'b0, 32'h0000_0006, '0);
      do_txn(1'b1, 1'b0, 32'h0000_0080, '0);
      do_txn(1'b1, 1'b0, 32'h0001_0000, '0);
      do_txn(1'b0, 1'b1, 32'h0, 8'd40);

      do_reset();
      do_txn(1'b1, 1'b1, 32'h0, 8'd5);
      do_txn(1'b1, 1'b1, 32'h0, 8'd5);
      do_txn(1'b0, 1'b1, 32'h0, 8'd9);
      do_txn(1'b1, 1'b1, 32'h14, 8'd7);

      held_test();

      // Reset asserted while the fetch is in CAP.
      @(negedge clk);
      if_req = 1'b1; if_pc = 32'h8;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_if_ack", 32'(if_ack), 32'h0);
      check("midrst_if_inst", if_inst, NOP);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_rom_addr", 32'(rom_addr), 32'h0);
      rst = 1'b0; if_req = 1'b0;
      model_reset();
      do_txn(1'b1, 1'b0, 32'h0000_0010, '0);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
            1: pc = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            2: pc = 32'($urandom_range(DEPTH, 255)) << 2;
            default: pc = $urandom | 32'h0001_0000;
         endcase
         case ($urandom_range(0, 2))
            0: do_txn(1'b1, 1'b0, pc, ADDR_W'($urandom_range(0, 63)));
            1: do_txn(1'b0, 1'b1, pc, ADDR_W'($urandom_range(0, 63)));
            default: do_txn(1'b1, 1'b1, pc, ADDR_W'($urandom_range(0, 63)));
         endcase
      end

      check("queue_empty", exp_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
